// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus values,
// stall patterns and divider FSM state encodings.
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_WD = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bit order {WB, MEM, EX, ID, IF, PC}
    localparam logic [STALL_BUS_WD-1:0] STALL_NONE     = {STALL_BUS_WD{NO_STOP}};
    localparam logic [STALL_BUS_WD-1:0] STALL_LOAD_USE = {{3{NO_STOP}}, {3{STOP}}};
    localparam logic [STALL_BUS_WD-1:0] STALL_EX_BUSY  = {{2{NO_STOP}}, {4{STOP}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID and EX stages (purely combinational).
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       ex_is_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_rf_waddr,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_rs_used && (id_rs == ex_rf_waddr);
    assign rt_hit = id_rt_used && (id_rt == ex_rf_waddr);

    // $0 is hardwired to zero, so a write to it can never be a real producer.
    assign load_use = ex_is_load && ex_rf_we && (ex_rf_waddr != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: load-use bubbles and fixed-latency divider sequencing.
// Optional macro STALL_PERF_CNT_EN adds saturating stall/divide counters on perf_bus.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_WD   = STALL_BUS_WD,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_WD     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic                ex_is_load,
    input  logic                ex_rf_we,
    input  logic [4:0]          ex_rf_waddr,
    input  logic                ex_div_req,
    output logic [STALL_WD-1:0] stall,
    output logic                div_start,
    output logic                div_done,
`ifdef STALL_PERF_CNT_EN
    output logic                busy,
    output logic [95:0]         perf_bus
`else
    output logic                busy
`endif
);

    localparam logic [CNT_WD-1:0] DIV_LOAD = CNT_WD'(DIV_CYCLES - 1);

    div_state_e        state_q;
    logic [CNT_WD-1:0] cnt_q;
    logic              div_done_q;
    logic              busy_q;
    logic              load_use;
    logic [STALL_WD-1:0] stall_d;

    pipe_stall_ctrl_hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .ex_is_load  (ex_is_load),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_waddr (ex_rf_waddr),
        .load_use    (load_use)
    );

    assign div_start = (state_q == ST_IDLE) && ex_div_req;

    always_comb begin
        stall_d = STALL_WD'(STALL_NONE);
        if (div_start || (state_q == ST_DIV_BUSY)) begin
            stall_d = STALL_WD'(STALL_EX_BUSY);
        end else if (load_use) begin
            stall_d = STALL_WD'(STALL_LOAD_USE);
        end
    end

    assign stall = stall_d;

    // The launch cycle plus DIV_CYCLES busy cycles (counter DIV_CYCLES-1 down to 0)
    // give DIV_CYCLES+1 stalled cycles before the single DIV_DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            div_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_div_req) begin
                        state_q <= ST_DIV_BUSY;
                        cnt_q   <= DIV_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DIV_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_DIV_DONE;
                        div_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_WD'(1);
                    end
                end
                ST_DIV_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_done = div_done_q;
    assign busy     = busy_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] load_use_cnt_q;
    logic [31:0] div_stall_cnt_q;
    logic [31:0] div_op_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_use_cnt_q  <= '0;
            div_stall_cnt_q <= '0;
            div_op_cnt_q    <= '0;
        end else begin
            if ((stall_d == STALL_WD'(STALL_LOAD_USE)) && (load_use_cnt_q != '1)) begin
                load_use_cnt_q <= load_use_cnt_q + 32'd1;
            end
            if ((stall_d == STALL_WD'(STALL_EX_BUSY)) && (div_stall_cnt_q != '1)) begin
                div_stall_cnt_q <= div_stall_cnt_q + 32'd1;
            end
            if (div_start && (div_op_cnt_q != '1)) begin
                div_op_cnt_q <= div_op_cnt_q + 32'd1;
            end
        end
    end

    assign perf_bus = {div_op_cnt_q, div_stall_cnt_q, load_use_cnt_q};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: load-use cases, divide timing, overlap,
// back-to-back divides and reset in the middle of a divide.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       ex_is_load;
    logic       ex_rf_we;
    logic [4:0] ex_rf_waddr;
    logic       ex_div_req;
    logic [5:0] stall;
    logic       div_start;
    logic       div_done;
    logic       busy;
`ifdef STALL_PERF_CNT_EN
    logic [95:0] perf_bus;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LU   = 6'b000111;
    localparam logic [5:0] S_DIV  = 6'b001111;

    pipe_stall_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .ex_is_load  (ex_is_load),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_waddr (ex_rf_waddr),
        .ex_div_req  (ex_div_req),
        .stall       (stall),
        .div_start   (div_start),
        .div_done    (div_done),
`ifdef STALL_PERF_CNT_EN
        .busy        (busy),
        .perf_bus    (perf_bus)
`else
        .busy        (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0; ex_div_req = 1'b0;
    endtask

    // EX holds lw $5; ID is addu $6,$5,$2
    task automatic set_load_use();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd5;
        id_rs = 5'd5; id_rs_used = 1'b1; id_rt = 5'd2; id_rt_used = 1'b1;
    endtask

    // Cycles T+1..T+32 of a divide: all stalled, no pulses.
    task automatic check_div_busy_window(input string tag);
        for (int k = 1; k <= 32; k++) begin
            #1;
            chk({tag, "_stall"}, 32'(stall), 32'(S_DIV));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_start"}, 32'(div_start), 32'd0);
            chk({tag, "_done"}, 32'(div_done), 32'd0);
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'(S_NONE));
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_done", 32'(div_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Load-use via rs: one bubble, then the load has moved on.
        set_load_use();
        #1;
        chk("lu_rs_stall", 32'(stall), 32'(S_LU));
        chk("lu_rs_busy", 32'(busy), 32'd0);
        tick();
        clear_inputs();
        id_rs = 5'd5; id_rs_used = 1'b1;
        #1;
        chk("lu_rs_release", 32'(stall), 32'(S_NONE));
        tick();

        // Load-use via rt only.
        clear_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd9;
        id_rt = 5'd9; id_rt_used = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        #1;
        chk("lu_rt_stall", 32'(stall), 32'(S_LU));
        id_rt_used = 1'b0;
        #1;
        chk("lu_rt_unused", 32'(stall), 32'(S_NONE));

        // $0 destination never hazards.
        clear_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd0;
        id_rs = 5'd0; id_rs_used = 1'b1;
        #1;
        chk("lu_r0", 32'(stall), 32'(S_NONE));

        // addiu $5 in EX (not a load).
        clear_inputs();
        ex_rf_we = 1'b1; ex_rf_waddr = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
        #1;
        chk("no_load", 32'(stall), 32'(S_NONE));

        // Load that does not write the register file.
        ex_is_load = 1'b1; ex_rf_we = 1'b0;
        #1;
        chk("load_no_we", 32'(stall), 32'(S_NONE));
        tick();

        // Divide with simultaneous load-use, request held while EX is frozen.
        clear_inputs();
        set_load_use();
        ex_div_req = 1'b1;
        #1;
        chk("div1_T_start", 32'(div_start), 32'd1);
        chk("div1_T_stall", 32'(stall), 32'(S_DIV));
        chk("div1_T_busy", 32'(busy), 32'd0);
        tick();
        check_div_busy_window("div1");
        // T+33: done cycle, request still high but ignored.
        clear_inputs();
        ex_div_req = 1'b1;
        #1;
        chk("div1_done", 32'(div_done), 32'd1);
        chk("div1_done_stall", 32'(stall), 32'(S_NONE));
        chk("div1_done_start", 32'(div_start), 32'd0);
        chk("div1_done_busy", 32'(busy), 32'd1);
        tick();

        // T+34: back in IDLE; the next divide arrives and is accepted.
        #1;
        chk("div1_idle_busy", 32'(busy), 32'd0);
        chk("div1_idle_done", 32'(div_done), 32'd0);
        chk("div2_T_start", 32'(div_start), 32'd1);
        chk("div2_T_stall", 32'(stall), 32'(S_DIV));
        tick();
        check_div_busy_window("div2");
        ex_div_req = 1'b0;
        #1;
        chk("div2_done", 32'(div_done), 32'd1);
        chk("div2_done_stall", 32'(stall), 32'(S_NONE));
        tick();
        #1;
        chk("div2_idle_busy", 32'(busy), 32'd0);
        chk("div2_idle_stall", 32'(stall), 32'(S_NONE));
        chk("div2_idle_start", 32'(div_start), 32'd0);
        tick();

        // Reset at counter=10 (cycle T+22) abandons the divide.
        ex_div_req = 1'b1;
        #1;
        chk("div3_T_start", 32'(div_start), 32'd1);
        tick();
        for (int k = 1; k < 22; k++) begin
            tick();
        end
        #1;
        chk("div3_pre_rst_stall", 32'(stall), 32'(S_DIV));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_div_req = 1'b0;
        #1;
        chk("div3_rst_stall", 32'(stall), 32'(S_NONE));
        chk("div3_rst_busy", 32'(busy), 32'd0);
        begin
            int done_seen;
            done_seen = 0;
            for (int k = 0; k < 20; k++) begin
                if (div_done) done_seen++;
                tick();
            end
            chk("div3_no_done", 32'(done_seen), 32'd0);
        end
        chk("div3_end_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
